// File: rtl/adc_bcd_scanner.sv
// Periodic ADC channel scanner: snapshots a selected channel, scales it and converts it to BCD
// with a sequential double-dabble. Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module adc_bcd_scanner #(
  parameter int NCH         = 4,
  parameter int SAMPLE_W    = 12,
  parameter int NDIG        = 7,
  parameter int SCALE_MUL   = 250000,
  parameter int SCALE_SHIFT = 10,
  parameter int PERIOD      = 10000000,
  parameter int FULL_CODE   = 4093,
  localparam int SCALED_W   = SAMPLE_W + $clog2(SCALE_MUL + 1),
  localparam int CW         = $clog2(NCH)
) (
  input  logic                CLK100MHZ,
  input  logic                RST_BTN,
  input  logic                smp_valid,
  input  logic [CW-1:0]       smp_ch,
  input  logic [SAMPLE_W-1:0] smp_data,
  input  logic [CW-1:0]       sel,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [NDIG-1:0]     blank,
  output logic                upd_valid,
  output logic                busy,
  output logic                ovf
);

  localparam int PCW = $clog2(PERIOD);
  localparam int BCW = $clog2(SCALED_W);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]       MAX_DISP = pow10(NDIG) - 64'd1;
  localparam logic [4*NDIG-1:0] FULL_BCD = {4'd1, {(4*(NDIG-1)){1'b0}}};
  localparam logic [4*NDIG-1:0] ALL9_BCD = {NDIG{4'd9}};

  typedef enum logic [1:0] {S_IDLE, S_SCALE, S_CONV, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [PCW-1:0]        cnt_q, cnt_d;
  logic                  tick;
  logic [SAMPLE_W-1:0]   smp_q [NCH];
  logic [SAMPLE_W-1:0]   smp_d [NCH];
  logic [SAMPLE_W-1:0]   sel_val;
  logic [SAMPLE_W-1:0]   snap_q, snap_d;
  logic [SCALED_W-1:0]   scaled;
  logic [SCALED_W-1:0]   bin_q, bin_d;
  logic [4*NDIG-1:0]     bcd_q, bcd_d;
  logic [4*NDIG-1:0]     dd_adj, dd_shift;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic                  ovf_wip_q, ovf_wip_d;
  logic [4*NDIG-1:0]     bcd_out_q, bcd_out_d;
  logic                  ovf_q, ovf_d;
  logic                  upd_valid_q, upd_valid_d;

  always_comb begin
    tick  = (cnt_q == PCW'(PERIOD - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Out-of-range channel indices are dropped rather than aliased onto a real channel.
  always_comb begin
    smp_d = smp_q;
    if (smp_valid && (32'(smp_ch) < NCH)) smp_d[smp_ch] = smp_data;
  end

  always_comb begin
    sel_val = '0;
    if (32'(sel) < NCH) sel_val = smp_q[sel];
  end

  // Full-width product so no precision is lost before the shift.
  always_comb begin
    scaled = SCALED_W'((SCALED_W'(snap_q) * SCALED_W'(SCALE_MUL)) >> SCALE_SHIFT);
  end

  always_comb begin
    dd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dd_shift = {dd_adj[4*NDIG-2:0], bin_q[SCALED_W-1]};
  end

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    bitcnt_d    = bitcnt_q;
    ovf_wip_d   = ovf_wip_q;
    bcd_out_d   = bcd_out_q;
    ovf_d       = ovf_q;
    upd_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          snap_d  = sel_val;
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        if (32'(snap_q) >= FULL_CODE) begin
          bcd_out_d   = FULL_BCD;
          ovf_d       = 1'b0;
          upd_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          bin_d     = scaled;
          bcd_d     = '0;
          bitcnt_d  = BCW'(SCALED_W - 1);
          ovf_wip_d = (64'(scaled) > MAX_DISP);
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d    = dd_shift;
        bin_d    = bin_q << 1;
        bitcnt_d = bitcnt_q - 1'b1;
        // Outputs load on the edge into DONE so they are already valid while upd_valid is high.
        if (bitcnt_q == '0) begin
          bcd_out_d   = ovf_wip_q ? ALL9_BCD : dd_shift;
          ovf_d       = ovf_wip_q;
          upd_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (!RST_BTN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      // NOTE: the sample memory is reset explicitly because a display after reset must show zero,
      // which forces it into flops rather than RAM.
      smp_q       <= '{default: '0};
      snap_q      <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      bitcnt_q    <= '0;
      ovf_wip_q   <= 1'b0;
      bcd_out_q   <= '0;
      ovf_q       <= 1'b0;
      upd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      smp_q       <= smp_d;
      snap_q      <= snap_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      bitcnt_q    <= bitcnt_d;
      ovf_wip_q   <= ovf_wip_d;
      bcd_out_q   <= bcd_out_d;
      ovf_q       <= ovf_d;
      upd_valid_q <= upd_valid_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] blank_q, blank_d;

  function automatic logic [NDIG-1:0] lead_blank(input logic [4*NDIG-1:0] d);
    logic [NDIG-1:0] b;
    logic            zero_above;
    b          = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      b[i]       = zero_above;
    end
    return b;
  endfunction

  always_comb begin
    blank_d = blank_q;
    if (upd_valid_d) blank_d = lead_blank(bcd_out_d);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!RST_BTN) blank_q <= '0;
    else          blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  assign bcd_out   = bcd_out_q;
  assign ovf       = ovf_q;
  assign upd_valid = upd_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule
